// File: rtl/display_scan_ctrl_pkg.sv
// ============================================================================
// Module      : display_scan_ctrl_pkg
// Description : Shared constants, scan state type and blanking helper for
//               the multiplexed seven-segment scan controller.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package display_scan_ctrl_pkg;

    localparam int         c_digits  = 4;
    localparam logic [3:0] c_an_off  = 4'b1111;
    localparam logic       c_dp_off  = 1'b1;

    typedef enum logic [0:0] {
        GAP  = 1'b0,
        SHOW = 1'b1
    } scan_state_t;

    // A digit is blanked when it and every more-significant nibble are zero;
    // digit 0 always stays visible so a zero value still shows "0".
    function automatic logic lz_blank(
        input logic [4*c_digits-1:0] val,
        input logic                  lzs,
        input logic [1:0]            k
    );
        if (!lzs || (k == 2'd0)) begin
            return 1'b0;
        end
        return ((val >> (4 * int'(k))) == '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/display_scan_ctrl_scan_timebase.sv
// ============================================================================
// Module      : display_scan_ctrl_scan_timebase
// Description : Slot counter and digit index with slot/frame end strobes.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module display_scan_ctrl_scan_timebase #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic [$clog2(REFRESH_DIV)-1:0] o_cnt,
    output logic [$clog2(DIGITS)-1:0]      o_idx,
    output logic                           o_slot_end,
    output logic                           o_frame_end
);

    localparam int c_cw = $clog2(REFRESH_DIV);
    localparam int c_iw = $clog2(DIGITS);

    logic [c_cw-1:0] r_cnt;
    logic [c_iw-1:0] r_idx;

    assign o_slot_end  = (r_cnt == c_cw'(REFRESH_DIV - 1));
    assign o_frame_end = o_slot_end && (r_idx == c_iw'(DIGITS - 1));
    assign o_cnt       = r_cnt;
    assign o_idx       = r_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (o_slot_end) begin
            r_cnt <= '0;
            r_idx <= (r_idx == c_iw'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/display_scan_ctrl.sv
// ============================================================================
// Module      : display_scan_ctrl
// Description : Time-multiplexed common-anode display scanner with guard gap,
//               frame-aligned value updates and leading-zero suppression.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int DIGITS      = c_digits,
    parameter int REFRESH_DIV = 100000,
    parameter int GAP_CYCLES  = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   Value,
    input  logic [DIGITS-1:0]     DpMask,
    input  logic                  Lzs,
    input  logic                  Load,
    output logic                  LoadAck,
    output logic [3:0]            D,
    output logic [DIGITS-1:0]     An,
    output logic                  Dp,
    output logic                  FrameDone
);

    localparam int c_cw = $clog2(REFRESH_DIV);
    localparam int c_iw = $clog2(DIGITS);

    logic [c_cw-1:0]     w_cnt;
    logic [c_iw-1:0]     w_idx;
    logic                w_slot_end;
    logic                w_frame_end;

    scan_state_t         r_state;
    scan_state_t         w_state_nxt;

    logic [4*DIGITS-1:0] r_pb_val;
    logic [DIGITS-1:0]   r_pb_dp;
    logic                r_pb_lzs;
    logic                r_pend;
    logic [4*DIGITS-1:0] r_sh_val;
    logic [DIGITS-1:0]   r_sh_dp;
    logic                r_sh_lzs;

    logic [DIGITS-1:0]   r_an;
    logic [3:0]          r_d;
    logic                r_dp;
    logic                r_ack;
    logic                r_fd;

    logic                w_lit;
    logic [3:0]          w_nib;

    display_scan_ctrl_scan_timebase #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) u_timebase (
        .clk         (clk),
        .rst         (rst),
        .o_cnt       (w_cnt),
        .o_idx       (w_idx),
        .o_slot_end  (w_slot_end),
        .o_frame_end (w_frame_end)
    );

    // The state tracks the same cnt value the timebase currently holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= GAP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            GAP:     if (w_cnt == c_cw'(GAP_CYCLES - 1)) w_state_nxt = SHOW;
            SHOW:    if (w_slot_end)                     w_state_nxt = GAP;
            default: w_state_nxt = GAP;
        endcase
    end

    // A Load on the boundary cycle bypasses the buffer and wins over it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pb_val <= '0;
            r_pb_dp  <= '0;
            r_pb_lzs <= 1'b0;
            r_pend   <= 1'b0;
            r_sh_val <= '0;
            r_sh_dp  <= '0;
            r_sh_lzs <= 1'b0;
            r_ack    <= 1'b0;
        end else begin
            r_ack <= w_frame_end && (Load || r_pend);
            if (w_frame_end) begin
                if (Load) begin
                    r_sh_val <= Value;
                    r_sh_dp  <= DpMask;
                    r_sh_lzs <= Lzs;
                end else if (r_pend) begin
                    r_sh_val <= r_pb_val;
                    r_sh_dp  <= r_pb_dp;
                    r_sh_lzs <= r_pb_lzs;
                end
                r_pend <= 1'b0;
            end else if (Load) begin
                r_pb_val <= Value;
                r_pb_dp  <= DpMask;
                r_pb_lzs <= Lzs;
                r_pend   <= 1'b1;
            end
        end
    end

    assign w_nib = r_sh_val[{w_idx, 2'b00} +: 4];
    assign w_lit = (r_state == SHOW) && !lz_blank(r_sh_val, r_sh_lzs, w_idx);

    // D follows idx even in the gap so the decoder is settled at turn-on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an <= c_an_off;
            r_d  <= 4'h0;
            r_dp <= c_dp_off;
            r_fd <= 1'b0;
        end else begin
            r_an <= w_lit ? ~(DIGITS'(1) << w_idx) : c_an_off;
            r_d  <= w_nib;
            r_dp <= (w_lit && r_sh_dp[w_idx]) ? 1'b0 : c_dp_off;
            r_fd <= (w_cnt == c_cw'(REFRESH_DIV - 2)) && (w_idx == c_iw'(DIGITS - 1));
        end
    end

    assign An        = r_an;
    assign D         = r_d;
    assign Dp        = r_dp;
    assign LoadAck   = r_ack;
    assign FrameDone = r_fd;

endmodule

`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
// ============================================================================
// Module      : tb_display_scan_ctrl
// Description : Self-checking bench for display_scan_ctrl with a frame-level
//               reference model and directed scenario pins.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_display_scan_ctrl;

    localparam int R = 8;
    localparam int G = 2;
    localparam int N = 4;
    localparam int F = N * R;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] Value = '0;
    logic [3:0]  DpMask = '0;
    logic        Lzs = 1'b0;
    logic        Load = 1'b0;
    logic        LoadAck;
    logic [3:0]  D;
    logic [3:0]  An;
    logic        Dp;
    logic        FrameDone;

    int checks = 0;
    int failures = 0;

    int          m_pos;
    logic [15:0] m_val, p_val;
    logic [3:0]  m_dp, p_dp;
    logic        m_lzs, p_lzs, p_pend;
    logic [3:0]  e_an, e_d;
    logic        e_dp, e_ack, e_fd;

    logic [3:0]  seen_d [4];
    logic [3:0]  seen_an [4];
    logic        seen_dp [4];
    int          ack_cnt;

    display_scan_ctrl #(
        .DIGITS      (N),
        .REFRESH_DIV (R),
        .GAP_CYCLES  (G)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Value     (Value),
        .DpMask    (DpMask),
        .Lzs       (Lzs),
        .Load      (Load),
        .LoadAck   (LoadAck),
        .D         (D),
        .An        (An),
        .Dp        (Dp),
        .FrameDone (FrameDone)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos  = 0;
        m_val  = '0; m_dp = '0; m_lzs = 1'b0;
        p_val  = '0; p_dp = '0; p_lzs = 1'b0; p_pend = 1'b0;
    endtask

    // Predict the outputs produced by the coming edge, advance the model,
    // then compare the DUT just after that edge.
    task automatic cycle();
        int   cnt, idx;
        logic lit, vis, bnd;
        cnt   = m_pos % R;
        idx   = (m_pos / R) % N;
        lit   = (cnt >= G);
        vis   = !(m_lzs && idx != 0 && ((m_val >> (4 * idx)) == 16'h0));
        e_d   = m_val[4*idx +: 4];
        e_an  = (lit && vis) ? ~(4'b0001 << idx) : 4'hF;
        e_dp  = !(lit && vis && m_dp[idx]);
        bnd   = (m_pos % F) == F - 1;
        e_ack = bnd && (Load || p_pend);
        e_fd  = ((m_pos + 1) % F) == F - 1;
        if (bnd) begin
            if (Load) begin
                m_val = Value; m_dp = DpMask; m_lzs = Lzs;
            end else if (p_pend) begin
                m_val = p_val; m_dp = p_dp; m_lzs = p_lzs;
            end
            p_pend = 1'b0;
        end else if (Load) begin
            p_val = Value; p_dp = DpMask; p_lzs = Lzs; p_pend = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("an", {12'h0, An}, {12'h0, e_an});
        chk("d", {12'h0, D}, {12'h0, e_d});
        chk("dp", {15'h0, Dp}, {15'h0, e_dp});
        chk("loadack", {15'h0, LoadAck}, {15'h0, e_ack});
        chk("framedone", {15'h0, FrameDone}, {15'h0, e_fd});
        if (LoadAck) ack_cnt++;
        if (cnt == R - 1) begin
            seen_d[idx]  = D;
            seen_an[idx] = An;
            seen_dp[idx] = Dp;
        end
        m_pos++;
    endtask

    task automatic to_frame_start();
        while (m_pos % F != 0) cycle();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] dpm, input logic lz);
        Value = v; DpMask = dpm; Lzs = lz; Load = 1'b1;
        cycle();
        Load = 1'b0;
    endtask

    initial begin
        ack_cnt = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", {12'h0, An}, 16'h000F);
        chk("rst_d", {12'h0, D}, 16'h0000);
        chk("rst_dp", {15'h0, Dp}, 16'h0001);
        chk("rst_ack", {15'h0, LoadAck}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // Edge-numbered startup pins of the lit window.
        for (int e = 1; e <= 12; e++) begin
            cycle();
            if (e == 2)  chk("start_an_e2", {12'h0, An}, 16'h000F);
            if (e == 3)  chk("start_an_e3", {12'h0, An}, 16'h000E);
            if (e == 8)  chk("start_an_e8", {12'h0, An}, 16'h000E);
            if (e == 9)  chk("start_an_e9", {12'h0, An}, 16'h000F);
            if (e == 10) chk("start_an_e10", {12'h0, An}, 16'h000F);
            if (e == 11) chk("start_an_e11", {12'h0, An}, 16'h000D);
        end

        // Mid-frame load appears only after the boundary.
        to_frame_start();
        run(10);
        ack_cnt = 0;
        load(16'h1A2F, 4'b0100, 1'b0);
        to_frame_start();
        run(F);
        chk("a_d0", {12'h0, seen_d[0]}, 16'h000F);
        chk("a_d1", {12'h0, seen_d[1]}, 16'h0002);
        chk("a_d2", {12'h0, seen_d[2]}, 16'h000A);
        chk("a_d3", {12'h0, seen_d[3]}, 16'h0001);
        chk("a_dp", {12'h0, seen_dp[3], seen_dp[2], seen_dp[1], seen_dp[0]}, 16'h000B);
        chk("a_acks", 16'(ack_cnt), 16'd1);

        // Leading-zero suppression, including DP on blanked digits.
        load(16'h0050, 4'b1111, 1'b1);
        to_frame_start();
        run(F);
        chk("lz_an3", {12'h0, seen_an[3]}, 16'h000F);
        chk("lz_an2", {12'h0, seen_an[2]}, 16'h000F);
        chk("lz_an1", {12'h0, seen_an[1]}, 16'h000D);
        chk("lz_an0", {12'h0, seen_an[0]}, 16'h000E);
        chk("lz_dp", {12'h0, seen_dp[3], seen_dp[2], seen_dp[1], seen_dp[0]}, 16'h000C);
        load(16'h0000, 4'b0000, 1'b1);
        to_frame_start();
        run(F);
        chk("lz0_an", {seen_an[3], seen_an[2], seen_an[1], seen_an[0]}, 16'hFFFE);

        // Last load in a frame wins; a single acknowledge.
        run(3);
        ack_cnt = 0;
        load(16'h1111, 4'b0000, 1'b0);
        run(5);
        load(16'h2222, 4'b0000, 1'b0);
        to_frame_start();
        run(F);
        chk("lw_d", {seen_d[3], seen_d[2], seen_d[1], seen_d[0]}, 16'h2222);
        chk("lw_acks", 16'(ack_cnt), 16'd1);

        // Load on the exact boundary cycle.
        while (m_pos % F != F - 1) cycle();
        load(16'hBEEF, 4'b0000, 1'b0);
        chk("beef_ack", {15'h0, LoadAck}, 16'h0001);
        run(F);
        chk("beef_d", {seen_d[3], seen_d[2], seen_d[1], seen_d[0]}, 16'hBEEF);

        // Asynchronous reset during digit 2 with a pending load.
        to_frame_start();
        run(3);
        load(16'h1234, 4'b1111, 1'b0);
        while (m_pos % F != 2 * R + 5) cycle();
        chk("pre_rst_an", {12'h0, An}, 16'h000B);
        #3 rst = 1'b1;
        #1;
        chk("arst_an", {12'h0, An}, 16'h000F);
        chk("arst_dp", {15'h0, Dp}, 16'h0001);
        chk("arst_d", {12'h0, D}, 16'h0000);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ack_cnt = 0;
        run(F + R);
        chk("rst_acks", 16'(ack_cnt), 16'd0);
        chk("rst_d_all", {seen_d[3], seen_d[2], seen_d[1], seen_d[0]}, 16'h0000);

        // Randomised loads against the model.
        for (int i = 0; i < 20 * F; i++) begin
            if ($urandom_range(0, 11) == 0) begin
                Value = 16'($urandom);
                case ($urandom_range(0, 3))
                    0:       Value = Value & 16'h000F;
                    1:       Value = Value & 16'h00FF;
                    2:       Value = Value & 16'h0F0F;
                    default: Value = Value;
                endcase
                DpMask = 4'($urandom);
                Lzs    = 1'($urandom);
                Load   = 1'b1;
            end
            cycle();
            Load = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexing controller that shares one hex-to-seven-segment decoder between the digits of a common-anode display. It holds a 16-bit display value in a shadow register, steps a digit index at a fixed refresh rate, and drives the decoder's 4-bit nibble input, the active-low anode enables and the decimal point. It inserts an all-off guard interval between digits to prevent ghosting, and it applies new values only at frame boundaries so a frame never shows a torn value. It sits between the application logic and the board-level decoder/display pins.

## Interface
- DIGITS, 4: number of multiplexed digits. Fixed at 4 for this revision; value width is 4*DIGITS.
- REFRESH_DIV, 100000: clock cycles per digit slot (1 kHz/digit at 100 MHz). Must be ≥ GAP_CYCLES+2.
- GAP_CYCLES, 1000: cycles at the start of each slot during which all anodes are off.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- Value  in  16  requested display value, nibble k → digit k (digit 0 rightmost).
- DpMask  in  4  decimal-point enables, bit k → digit k; sampled with Value.
- Lzs  in  1  leading-zero suppression enable; sampled with Value.
- Load  in  1  one-cycle request to capture Value/DpMask/Lzs.
- LoadAck  out  1  one-cycle pulse when the captured value becomes active.
- D  out  4  nibble to the decoder.
- An  out  4  anode enables, active-low, one-hot-low or all high.
- Dp  out  1  decimal point, active-low.
- FrameDone  out  1  one-cycle pulse on the last cycle of digit DIGITS-1.

## Operation
- Registers: slot counter cnt (0..REFRESH_DIV-1), digit index idx (0..DIGITS-1), state, pending buffer (val/dp/lzs + pend flag), active shadow (val/dp/lzs).
- States: GAP (cnt < GAP_CYCLES) and SHOW (cnt ≥ GAP_CYCLES). These are derived from cnt and registered as a state bit.
- GAP: An=4'b1111, Dp=1. D already carries the nibble for idx so the decoder settles before the anode turns on.
- SHOW: An[idx]=0 and the other bits are 1; D=shadow nibble idx; Dp=~shadow_dp[idx].
- Slot end: cnt==REFRESH_DIV-1 → cnt←0, idx←idx+1 (wraps DIGITS-1→0).
- Leading-zero suppression: when shadow_lzs=1, digit k is blanked (An[k] stays high in SHOW) if nibbles k..DIGITS-1 are all zero and k≠0. Digit 0 is always shown. A DP on a blanked digit is also suppressed.
- Load: captures inputs into the pending buffer and sets pend. A later Load before the frame boundary overwrites the buffer (last-wins).
- Frame boundary: the cycle where idx==DIGITS-1 and cnt==REFRESH_DIV-1. If pend (or Load in that same cycle, which takes priority over the buffer), then shadow←pending/inputs, pend←0, and LoadAck pulses on the following cycle, i.e. the first cycle of digit 0.
- All outputs are registered; no combinational path from inputs to outputs.

## Timing
- Reset (async assert, sync release): cnt=0, idx=0, state=GAP, shadow=0, pend=0, An=4'b1111, D=4'h0, Dp=1, LoadAck=0, FrameDone=0.
- Output latency: one cycle from an internal cnt/idx change to An/D/Dp.
- Per slot: GAP_CYCLES cycles dark, then REFRESH_DIV-GAP_CYCLES cycles lit.
- Frame: DIGITS*REFRESH_DIV cycles. FrameDone is high exactly once per frame.
- Load→display latency: worst case one frame plus one cycle. A Load on the boundary cycle is displayed from the next slot onward.
- Reset mid-frame: display goes dark immediately, pend is discarded, and scanning restarts at digit 0 in GAP.

## Structure
- Shared package: DIGITS default, active-low constants AN_OFF=4'b1111 and DP_OFF=1'b1, and a state enum {GAP, SHOW}.
- One natural sub-module: scan_timebase, which holds cnt/idx and emits slot_end and frame_end strobes. The main block holds the load buffer, shadow and output logic.
- The decoder is not instantiated here; the top level wires D to it.

## Test plan
Bench parameters: REFRESH_DIV=8, GAP_CYCLES=2.
- Reset, hold → An=4'b1111, Dp=1, D=0. After release, An=4'b1110 at cycles 3..8 (one-cycle output latency), then digit 1 pattern 4'b1101 starts from cycle 11.
- Load Value=16'h1A2F, DpMask=4'b0100 mid-frame → no change until the boundary. Next frame: D sequence F,2,A,1; Dp low only during digit 2 SHOW; LoadAck exactly one pulse at the start of digit 0.
- Lzs=1, Value=16'h0050 → digits 3 and 2 keep An high all frame; digits 1 (5) and 0 (0) are lit. Value=16'h0000 → only digit 0 is lit.
- Two Loads (16'h1111 then 16'h2222) in the same frame → only 16'h2222 is displayed; one LoadAck.
- Load 16'hBEEF on the exact boundary cycle → shadow=16'hBEEF for the next frame; LoadAck on the following cycle.
- Assert rst during digit 2 SHOW with pend set → An=4'b1111 asynchronously. After release, scanning restarts at digit 0 showing 16'h0000, with no LoadAck.
